// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared timebase types: FSM encoding and tap bit mapping
package tick_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } tick_state_e;

    // Geometric spread of NTAPS taps across a WIDTH-bit counter, first tap at bit 0, last at the MSB
    function automatic int tap_bit(input int i, input int width, input int ntaps);
        return (i * (width - 1)) / (ntaps - 1);
    endfunction

endpackage

// File: rtl/tap_strobe_gen.sv
// rtl/tap_strobe_gen.sv - registered one-cycle tap strobes from the pre-advance count
module tap_strobe_gen
    import tick_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int NTAPS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             adv_i,
    input  logic             sync_i,
    output logic [NTAPS-1:0] taps_o
);

    logic [WIDTH-1:0] cnt_nxt;
    logic [NTAPS-1:0] fire;
    logic [NTAPS-1:0] taps_q;
    logic [NTAPS-1:0] taps_d;

    assign cnt_nxt = cnt_i + WIDTH'(1);

    // A tap fires when the new count has bit B set and all bits below it clear; the wrap to 0 never matches
    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
        localparam int B = tap_bit(g, WIDTH, NTAPS);
        localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << B) - WIDTH'(1);
        assign fire[g] = cnt_nxt[B] && ((cnt_nxt & LOW_MASK) == '0);
    end

    always_comb begin
        taps_d = '0;
        if (adv_i && !sync_i) begin
            taps_d = fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/tap_prescaler.sv
// rtl/tap_prescaler.sv - free-running prescale timebase with run/halt/burst control and tap strobes
module tap_prescaler
    import tick_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int NTAPS = 6,
    parameter int STEPW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_req,
    input  logic [STEPW-1:0] step_n,
    input  logic             sync,
    output logic [NTAPS-1:0] taps,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             step_done
);

    tick_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             adv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (sync) begin
            // Realign phase; a burst in flight is abandoned without a completion pulse
            cnt_d = '0;
            rem_d = '0;
            if (state_q == BURST) begin
                state_d = HALT;
            end
        end else begin
            unique case (state_q)
                HALT: begin
                    if (run) begin
                        state_d = RUN;
                    end else if (step_req) begin
                        if (step_n != '0) begin
                            state_d = BURST;
                            rem_d   = step_n;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run) begin
                        adv = 1'b1;
                    end else begin
                        state_d = HALT;
                    end
                end
                BURST: begin
                    adv   = 1'b1;
                    rem_d = rem_q - STEPW'(1);
                    if (rem_q == STEPW'(1)) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = HALT;
            endcase
            if (adv) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HALT;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    tap_strobe_gen #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS)
    ) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .cnt_i  (cnt_q),
        .adv_i  (adv),
        .sync_i (sync),
        .taps_o (taps)
    );

    assign cnt       = cnt_q;
    assign busy      = (state_q == BURST);
    assign step_done = done_q;

endmodule

// File: tb/tb_tap_prescaler.sv
// tb/tb_tap_prescaler.sv - scoreboard bench for tap_prescaler at WIDTH=11, NTAPS=3
module tb_tap_prescaler;

    localparam int WIDTH = 11;
    localparam int NTAPS = 3;
    localparam int STEPW = 16;

    typedef struct packed {
        logic [NTAPS-1:0] taps;
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             step_req = 1'b0;
    logic [STEPW-1:0] step_n = '0;
    logic             sync = 1'b0;
    logic [NTAPS-1:0] taps;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             step_done;

    int n_run  = 0;
    int n_fail = 0;

    exp_t sb[$];
    exp_t e;

    int               tb_bit [NTAPS] = '{0, 5, 10};
    int               m_st  = 0;
    logic [WIDTH-1:0] m_cnt = '0;
    logic [STEPW-1:0] m_rem = '0;

    tap_prescaler #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS),
        .STEPW (STEPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step_req  (step_req),
        .step_n    (step_n),
        .sync      (sync),
        .taps      (taps),
        .cnt       (cnt),
        .busy      (busy),
        .step_done (step_done)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the reference model, queue the expected post-edge outputs
    task automatic tick(input logic r, input logic ru, input logic sr, input logic [STEPW-1:0] sn,
                        input logic sy);
        exp_t             x;
        logic             adv;
        logic [WIDTH-1:0] old;
        rst = r; run = ru; step_req = sr; step_n = sn; sync = sy;
        @(posedge clk);
        x   = '0;
        adv = 1'b0;
        if (r) begin
            m_st = 0; m_cnt = '0; m_rem = '0;
        end else if (sy) begin
            m_cnt = '0;
            if (m_st == 2) m_st = 0;
        end else if (m_st == 0) begin
            if (ru) m_st = 1;
            else if (sr && sn != 0) begin m_st = 2; m_rem = sn; end
            else if (sr) x.done = 1'b1;
        end else if (m_st == 1) begin
            if (ru) adv = 1'b1; else m_st = 0;
        end else begin
            adv = 1'b1;
            if (m_rem == 1) begin m_st = 0; x.done = 1'b1; end
            m_rem = m_rem - 1'b1;
        end
        if (adv) begin
            old   = m_cnt;
            m_cnt = m_cnt + 1'b1;
            for (int i = 0; i < NTAPS; i++)
                x.taps[i] = !old[tb_bit[i]] && m_cnt[tb_bit[i]];
        end
        x.cnt  = m_cnt;
        x.busy = (m_st == 2);
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 1, 16'd5, 0);
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL reset: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
        end
        n_run++;
        if (cnt !== '0 || taps !== '0) begin
            n_fail++;
            $display("FAIL reset_zero: got cnt=%0d taps=%b, want 0/000", cnt, taps);
        end
    endtask

    task automatic test_run();
        int first [NTAPS];
        int hits  [NTAPS];
        int prev;
        for (int i = 0; i < NTAPS; i++) begin first[i] = -1; hits[i] = 0; end
        prev = 0;
        for (int k = 0; k < 2100; k++) begin
            tick(0, 1, 0, 0, 0);
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL run cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
            if (cnt == 0 && prev == 2047) begin
                n_run++;
                if (taps !== '0) begin
                    n_fail++;
                    $display("FAIL run_wrap: got taps=%b, want 000", taps);
                end
            end
            for (int i = 0; i < NTAPS; i++) if (taps[i] === 1'b1) begin
                hits[i]++;
                if (first[i] < 0) first[i] = int'(cnt);
            end
            prev = int'(cnt);
        end
        n_run++;
        if (first[0] != 1 || first[1] != 32 || first[2] != 1024) begin
            n_fail++;
            $display("FAIL run_first: got %0d/%0d/%0d, want 1/32/1024", first[0], first[1], first[2]);
        end
        n_run++;
        if (hits[0] != 1050 || hits[1] != 33 || hits[2] != 1) begin
            n_fail++;
            $display("FAIL run_hits: got %0d/%0d/%0d, want 1050/33/1", hits[0], hits[1], hits[2]);
        end
    endtask

    task automatic test_burst();
        int nbusy, ndone, nt1, t1cnt, donefall;
        nbusy = 0; ndone = 0; nt1 = 0; t1cnt = -1; donefall = 1;
        tick(0, 0, 0, 0, 0);
        void'(sb.pop_front());
        tick(0, 0, 0, 0, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 72; k++) begin
            if (k == 0) tick(0, 0, 1, 16'd64, 0);
            else        tick(0, 0, 0, 0, 0);
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
            if (busy === 1'b1) nbusy++;
            if (step_done === 1'b1) begin ndone++; if (busy !== 1'b0) donefall = 0; end
            if (taps[1] === 1'b1) begin nt1++; t1cnt = int'(cnt); end
        end
        n_run++;
        if (nbusy != 64 || cnt !== 11'd64 || ndone != 1 || donefall != 1) begin
            n_fail++;
            $display("FAIL burst_64: got busy_cycles=%0d cnt=%0d dones=%0d, want 64/64/1", nbusy, cnt, ndone);
        end
        n_run++;
        if (nt1 != 1 || t1cnt != 32) begin
            n_fail++;
            $display("FAIL burst_tap1: got hits=%0d at cnt=%0d, want 1 at 32", nt1, t1cnt);
        end
    endtask

    task automatic test_zero_step();
        tick(0, 0, 1, 16'd0, 0);
        e = sb.pop_front();
        n_run++;
        if ({taps, cnt, busy, step_done} !== e || step_done !== 1'b1 || cnt !== 11'd64 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_step: got cnt=%0d busy=%b done=%b, want cnt=64 busy=0 done=1", cnt, busy, step_done);
        end
        tick(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_run++;
        if ({taps, cnt, busy, step_done} !== e) begin
            n_fail++;
            $display("FAIL zero_step_after: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                     cnt, busy, step_done, e.cnt, e.busy, e.done);
        end
    endtask

    task automatic test_sync_burst();
        int ndone;
        ndone = 0;
        for (int k = 0; k < 41; k++) begin
            if (k == 0) tick(0, 0, 1, 16'd100, 0);
            else        tick(0, 0, 0, 0, 0);
            void'(sb.pop_front());
        end
        tick(0, 0, 0, 0, 1);
        e = sb.pop_front();
        n_run++;
        if ({taps, cnt, busy, step_done} !== e || cnt !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_abort: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0", cnt, busy, step_done);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 2) tick(0, 0, 1, 16'd3, 0);
            else        tick(0, 0, 0, 0, 0);
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL sync_restep cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
            if (step_done === 1'b1) ndone++;
        end
        n_run++;
        if (cnt !== 11'd3 || ndone != 1) begin
            n_fail++;
            $display("FAIL sync_restep_end: got cnt=%0d dones=%0d, want 3/1", cnt, ndone);
        end
    endtask

    task automatic test_halt_resume();
        tick(0, 0, 0, 0, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 501; k++) begin
            tick(0, 1, 0, 0, 0);
            void'(sb.pop_front());
        end
        n_run++;
        if (cnt !== 11'd500) begin
            n_fail++;
            $display("FAIL resume_pre: got cnt=%0d, want 500", cnt);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 3) tick(0, 0, 0, 0, 0);
            else       tick(0, 1, 0, 0, 0);
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL resume cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
            if (k == 2) begin
                n_run++;
                if (cnt !== 11'd500 || taps !== '0) begin
                    n_fail++;
                    $display("FAIL halt_hold: got cnt=%0d taps=%b, want 500/000", cnt, taps);
                end
            end
        end
        n_run++;
        if (cnt !== 11'd504) begin
            n_fail++;
            $display("FAIL resume_cnt: got cnt=%0d, want 504", cnt);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 8; k++) begin
            case (k)
                0:       tick(0, 1, 1, 16'd9, 0);
                2:       tick(0, 0, 0, 0, 0);
                4:       tick(0, 0, 1, 16'd9, 1);
                default: tick(0, (k < 2) ? 1'b1 : 1'b0, 0, 0, 0);
            endcase
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL simul cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 24; k++) begin
            case (k)
                0:       tick(0, 0, 1, 16'd50, 0);
                10:      tick(1, 0, 0, 0, 0);
                14:      tick(0, 1, 0, 0, 0);
                20:      tick(1, 1, 0, 0, 0);
                default: tick(0, (k > 14 && k < 20) ? 1'b1 : 1'b0, 0, 0, 0);
            endcase
            e = sb.pop_front();
            n_run++;
            if ({taps, cnt, busy, step_done} !== e) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want taps=%b cnt=%0d busy=%b done=%b",
                         k, taps, cnt, busy, step_done, e.taps, e.cnt, e.busy, e.done);
            end
            if (k == 10 || k == 20) begin
                n_run++;
                if ({taps, cnt, busy, step_done} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_zero cyc %0d: got taps=%b cnt=%0d busy=%b done=%b, want all 0",
                             k, taps, cnt, busy, step_done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_burst();
        test_zero_step();
        test_sync_burst();
        test_halt_resume();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
